// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors referee and display path.
package rps_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    SCISSORS = 2'b01,
    PAPER    = 2'b10,
    MOVE_BAD = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    RES_DRAW = 2'b00,
    RES_USER = 2'b01,
    RES_COMP = 2'b10,
    RES_VOID = 2'b11
  } result_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StJudge,
    StDone
  } ref_state_e;

  // True when move a defeats move b (illegal moves never win).
  function automatic logic beats(input move_e a, input move_e b);
    return ((a == ROCK)     && (b == SCISSORS)) ||
           ((a == SCISSORS) && (b == PAPER))    ||
           ((a == PAPER)    && (b == ROCK));
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge; shared by the referee and the display path.
module rps_judge
  import rps_pkg::*;
(
  input  move_e   user_move_i,
  input  move_e   comp_move_i,
  input  logic    void_i,
  output result_e result_o
);

  // Void wins over everything; otherwise apply the beats relation.
  always_comb begin
    result_o = RES_DRAW;
    if (void_i || (user_move_i == MOVE_BAD) || (comp_move_i == MOVE_BAD)) begin
      result_o = RES_VOID;
    end else if (user_move_i == comp_move_i) begin
      result_o = RES_DRAW;
    end else if (beats(user_move_i, comp_move_i)) begin
      result_o = RES_USER;
    end else begin
      result_o = RES_COMP;
    end
  end

endmodule

// File: rtl/rps_referee.sv
// Game-flow controller and scorer: hands player moves to the learner, judges
// rounds and keeps match score. Optional RPS_REFEREE_STREAK_EN adds computer
// win-streak outputs.
module rps_referee
  import rps_pkg::*;
#(
  parameter int unsigned MAX_GAMES     = 60,
  parameter int unsigned LEARN_TIMEOUT = 255,
  parameter int unsigned CNT_W         = $clog2(MAX_GAMES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             move_valid,
  input  logic [1:0]       move,
  output logic             move_ready,
  output logic [1:0]       user_choice,
  output logic             learn_start,
  input  logic             learn_ready,
  input  logic [1:0]       learn_choice,
  output logic             result_valid,
  output logic [1:0]       result,
  output logic [CNT_W-1:0] user_score,
  output logic [CNT_W-1:0] comp_score,
  output logic [CNT_W-1:0] draw_count,
  output logic [CNT_W-1:0] game_count,
  output logic             illegal_move,
  output logic             timeout_err,
`ifdef RPS_REFEREE_STREAK_EN
  output logic [CNT_W-1:0] comp_streak,
  output logic [CNT_W-1:0] best_comp_streak,
`endif
  output logic             match_over
);

  localparam int unsigned WaitW = (LEARN_TIMEOUT > 1) ? $clog2(LEARN_TIMEOUT + 1) : 1;

  ref_state_e       state_q, state_d;
  move_e            user_choice_q, user_choice_d;
  move_e            comp_choice_q, comp_choice_d;
  logic             void_q, void_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  result_e          result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] user_score_q, user_score_d;
  logic [CNT_W-1:0] comp_score_q, comp_score_d;
  logic [CNT_W-1:0] draw_count_q, draw_count_d;
  logic [CNT_W-1:0] game_count_q, game_count_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  result_e          judge_res;
`ifdef RPS_REFEREE_STREAK_EN
  logic [CNT_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0] best_q, best_d;
`endif

  rps_judge u_judge (
    .user_move_i (user_choice_q),
    .comp_move_i (comp_choice_q),
    .void_i      (void_q),
    .result_o    (judge_res)
  );

  // Next-state and score update; result and score registers change together.
  always_comb begin
    state_d        = state_q;
    user_choice_d  = user_choice_q;
    comp_choice_d  = comp_choice_q;
    void_d         = void_q;
    wait_cnt_d     = wait_cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    user_score_d   = user_score_q;
    comp_score_d   = comp_score_q;
    draw_count_d   = draw_count_q;
    game_count_d   = game_count_q;
    illegal_d      = 1'b0;
    timeout_d      = timeout_q;
`ifdef RPS_REFEREE_STREAK_EN
    streak_d       = streak_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (move_valid) begin
          if (move == 2'b11) begin
            illegal_d = 1'b1;
          end else begin
            user_choice_d = move_e'(move);
            state_d       = StIssue;
          end
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        void_d     = 1'b0;
        state_d    = StWait;
      end
      StWait: begin
        if (learn_ready) begin
          comp_choice_d = move_e'(learn_choice);
          state_d       = StJudge;
        end else if (wait_cnt_q == WaitW'(LEARN_TIMEOUT - 1)) begin
          void_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = StJudge;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StJudge: begin
        result_d       = judge_res;
        result_valid_d = 1'b1;
        state_d        = StIdle;
        if (judge_res != RES_VOID) begin
          case (judge_res)
            RES_USER: user_score_d = user_score_q + CNT_W'(1);
            RES_COMP: comp_score_d = comp_score_q + CNT_W'(1);
            default:  draw_count_d = draw_count_q + CNT_W'(1);
          endcase
`ifdef RPS_REFEREE_STREAK_EN
          streak_d = (judge_res == RES_COMP) ? streak_q + CNT_W'(1) : '0;
`endif
          game_count_d = game_count_q + CNT_W'(1);
          if (game_count_d == CNT_W'(MAX_GAMES)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
`ifdef RPS_REFEREE_STREAK_EN
    best_d = (streak_d > best_q) ? streak_d : best_q;
`endif
  end

  // State and score registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      user_choice_q  <= ROCK;
      comp_choice_q  <= ROCK;
      void_q         <= 1'b0;
      wait_cnt_q     <= '0;
      result_q       <= RES_DRAW;
      result_valid_q <= 1'b0;
      user_score_q   <= '0;
      comp_score_q   <= '0;
      draw_count_q   <= '0;
      game_count_q   <= '0;
      illegal_q      <= 1'b0;
      timeout_q      <= 1'b0;
`ifdef RPS_REFEREE_STREAK_EN
      streak_q       <= '0;
      best_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      user_choice_q  <= user_choice_d;
      comp_choice_q  <= comp_choice_d;
      void_q         <= void_d;
      wait_cnt_q     <= wait_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      user_score_q   <= user_score_d;
      comp_score_q   <= comp_score_d;
      draw_count_q   <= draw_count_d;
      game_count_q   <= game_count_d;
      illegal_q      <= illegal_d;
      timeout_q      <= timeout_d;
`ifdef RPS_REFEREE_STREAK_EN
      streak_q       <= streak_d;
      best_q         <= best_d;
`endif
    end
  end

  // State-decoded handshake outputs follow reset immediately.
  assign move_ready   = (state_q == StIdle);
  assign learn_start  = (state_q == StIssue);
  assign match_over   = (state_q == StDone);
  assign user_choice  = user_choice_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign user_score   = user_score_q;
  assign comp_score   = comp_score_q;
  assign draw_count   = draw_count_q;
  assign game_count   = game_count_q;
  assign illegal_move = illegal_q;
  assign timeout_err  = timeout_q;
`ifdef RPS_REFEREE_STREAK_EN
  assign comp_streak      = streak_q;
  assign best_comp_streak = best_q;
`endif

endmodule

// File: tb/tb_rps_referee.sv
// Directed bench for rps_referee; also covers RPS_REFEREE_STREAK_EN when defined.
module tb_rps_referee;
  import rps_pkg::*;

  localparam int unsigned CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             move_valid = 1'b0;
  logic [1:0]       move = 2'b00;
  logic             move_ready;
  logic [1:0]       user_choice;
  logic             learn_start;
  logic             learn_ready = 1'b0;
  logic [1:0]       learn_choice = 2'b00;
  logic             result_valid;
  logic [1:0]       result;
  logic [CNT_W-1:0] user_score, comp_score, draw_count, game_count;
  logic             illegal_move, timeout_err, match_over;
`ifdef RPS_REFEREE_STREAK_EN
  logic [CNT_W-1:0] comp_streak, best_comp_streak;
  int               exp_streak, exp_best;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int exp_user, exp_comp, exp_draw, exp_games;

  rps_referee dut (
    .clock        (clock),
    .reset        (reset),
    .move_valid   (move_valid),
    .move         (move),
    .move_ready   (move_ready),
    .user_choice  (user_choice),
    .learn_start  (learn_start),
    .learn_ready  (learn_ready),
    .learn_choice (learn_choice),
    .result_valid (result_valid),
    .result       (result),
    .user_score   (user_score),
    .comp_score   (comp_score),
    .draw_count   (draw_count),
    .game_count   (game_count),
    .illegal_move (illegal_move),
    .timeout_err  (timeout_err),
`ifdef RPS_REFEREE_STREAK_EN
    .comp_streak      (comp_streak),
    .best_comp_streak (best_comp_streak),
`endif
    .match_over   (match_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero();
    chk("rst_move_ready", move_ready, 1);
    chk("rst_learn_start", learn_start, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_user_choice", user_choice, 0);
    chk("rst_user_score", user_score, 0);
    chk("rst_comp_score", comp_score, 0);
    chk("rst_draw_count", draw_count, 0);
    chk("rst_game_count", game_count, 0);
    chk("rst_illegal", illegal_move, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_match_over", match_over, 0);
`ifdef RPS_REFEREE_STREAK_EN
    chk("rst_streak", comp_streak, 0);
    chk("rst_best", best_comp_streak, 0);
`endif
  endtask

  task automatic clear_model();
    exp_user = 0; exp_comp = 0; exp_draw = 0; exp_games = 0;
`ifdef RPS_REFEREE_STREAK_EN
    exp_streak = 0; exp_best = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_idle_zero();
    clear_model();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One round with learner answering in the first WAIT cycle; r is the
  // hand-computed result for (u, c).
  task automatic play(input logic [1:0] u, input logic [1:0] c, input logic [1:0] r);
    @(negedge clock);
    move_valid = 1'b1; move = u; learn_choice = c;
    @(negedge clock);                          // after accept edge: ISSUE
    move_valid = 1'b0; learn_ready = 1'b1;
    chk("start_pulse", learn_start, 1);
    chk("busy_not_ready", move_ready, 0);
    @(negedge clock);                          // WAIT
    chk("start_once", learn_start, 0);
    @(negedge clock);                          // JUDGE
    learn_ready = 1'b0;
    chk("no_early_valid", result_valid, 0);
    chk("games_hold", game_count, exp_games);
    case (r)
      2'd0: exp_draw++;
      2'd1: exp_user++;
      2'd2: exp_comp++;
      default: ;
    endcase
    if (r != 2'd3) exp_games++;
`ifdef RPS_REFEREE_STREAK_EN
    if (r == 2'd2) exp_streak++;
    else if (r != 2'd3) exp_streak = 0;
    if (exp_streak > exp_best) exp_best = exp_streak;
`endif
    @(negedge clock);                          // 3 cycles after accept
    chk("result_valid", result_valid, 1);
    chk("result", result, r);
    chk("user_choice", user_choice, u);
    chk("user_score", user_score, exp_user);
    chk("comp_score", comp_score, exp_comp);
    chk("draw_count", draw_count, exp_draw);
    chk("game_count", game_count, exp_games);
`ifdef RPS_REFEREE_STREAK_EN
    chk("comp_streak", comp_streak, exp_streak);
    chk("best_streak", best_comp_streak, exp_best);
`endif
    @(negedge clock);
    chk("valid_one_cycle", result_valid, 0);
  endtask

  initial begin
    logic [1:0] pu [3];
    logic [1:0] pc [3];
    logic [1:0] pr [3];
    int idx;
    pu[0] = ROCK;     pc[0] = SCISSORS; pr[0] = RES_USER;
    pu[1] = SCISSORS; pc[1] = ROCK;     pr[1] = RES_COMP;
    pu[2] = ROCK;     pc[2] = ROCK;     pr[2] = RES_DRAW;

    do_reset();

    play(ROCK, PAPER, RES_COMP);
    play(SCISSORS, PAPER, RES_USER);
    play(PAPER, PAPER, RES_DRAW);

    // Illegal move: pulse only, nothing else moves.
    @(negedge clock);
    move_valid = 1'b1; move = 2'b11;
    @(negedge clock);
    move_valid = 1'b0;
    chk("illegal_pulse", illegal_move, 1);
    chk("illegal_no_start", learn_start, 0);
    chk("illegal_stay_idle", move_ready, 1);
    chk("illegal_choice_kept", user_choice, PAPER);
    @(negedge clock);
    chk("illegal_one_cycle", illegal_move, 0);
    chk("illegal_no_start2", learn_start, 0);
    chk("illegal_games", game_count, exp_games);

    // Learner answers with an illegal move: void round.
    play(ROCK, MOVE_BAD, RES_VOID);

    // Timeout: learner never answers.
    @(negedge clock);
    move_valid = 1'b1; move = ROCK; learn_ready = 1'b0;
    @(negedge clock);                          // ISSUE
    move_valid = 1'b0;
    repeat (255) @(negedge clock);             // last WAIT cycle
    chk("to_not_yet", timeout_err, 0);
    chk("to_no_valid", result_valid, 0);
    @(negedge clock);                          // JUDGE
    chk("to_err_set", timeout_err, 1);
    chk("to_valid_late", result_valid, 0);
    @(negedge clock);
    chk("to_valid", result_valid, 1);
    chk("to_result", result, RES_VOID);
    chk("to_games", game_count, exp_games);
    chk("to_ready_back", move_ready, 1);
    @(negedge clock);
    chk("to_sticky", timeout_err, 1);

`ifdef RPS_REFEREE_STREAK_EN
    play(PAPER, SCISSORS, RES_COMP);
    play(PAPER, SCISSORS, RES_COMP);
    play(PAPER, SCISSORS, RES_COMP);
    play(ROCK, ROCK, RES_DRAW);
    chk("best_after_draw", best_comp_streak, 3);
`endif

    // Fill out the match.
    idx = 0;
    while (exp_games < 59) begin
      play(pu[idx], pc[idx], pr[idx]);
      idx = (idx + 1) % 3;
    end
    chk("not_over_59", match_over, 0);
    play(pu[idx], pc[idx], pr[idx]);
    chk("match_over", match_over, 1);
    chk("done_not_ready", move_ready, 0);
    chk("done_games", game_count, 60);
    move_valid = 1'b1; move = ROCK;
    repeat (4) begin
      @(negedge clock);
      chk("done_ignore_start", learn_start, 0);
    end
    move_valid = 1'b0;
    chk("done_games_held", game_count, 60);
    chk("done_held", match_over, 1);

    // Reset out of DONE, then reset mid-WAIT with a nonzero score.
    do_reset();
    play(ROCK, PAPER, RES_COMP);
    @(negedge clock);
    move_valid = 1'b1; move = PAPER;
    @(negedge clock);                          // ISSUE
    move_valid = 1'b0;
    @(negedge clock);                          // WAIT
    chk("pre_rst_score", comp_score, 1);
    reset = 1'b1;
    #1;
    chk_idle_zero();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_idle", move_ready, 1);
    chk("post_rst_no_valid", result_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
